gpu_bank_arbiter: RTL and testbench

// Sequences access to the banked vector register file (4 warps x 32 lanes x 64b; bank = reg[1:0]).

---
 rtl/gpu_bank_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_gpu_bank_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gpu_bank_arbiter.sv
// Purpose : arbitrates per-warp operand reads (round-robin) against a capped-priority writeback
//           port for the banked vector register file, splitting same-bank operand pairs over two cycles.
// Latency : accept at cycle N -> bank op on registered outputs at N+1 (second half of a split at N+2).
// Backpr. : req_ready/wb_ready are combinational grants; no accept while a split read is in its first half.
// Ports   : clk/rst_n (sync active-low); req_valid/req_ready/req_src0/req_src1 per-warp read request;
//           wb_valid/wb_ready/wb_warp/wb_reg writeback request; read_bank/write_bank/bank_warp_num,
//           rd_en0/rd_en1/rd_addr0/rd_addr1/wr_addr bank controls; rd_done_valid/rd_done_warp read completion.
module gpu_bank_arbiter #(
  parameter int NUM_WARPS     = 4,
  parameter int WARP_W        = 2,
  parameter int REG_W         = 5,
  parameter int WB_STREAK_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_WARPS-1:0]       req_valid,
  output logic [NUM_WARPS-1:0]       req_ready,
  input  logic [NUM_WARPS*REG_W-1:0] req_src0,
  input  logic [NUM_WARPS*REG_W-1:0] req_src1,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [WARP_W-1:0]          wb_warp,
  input  logic [REG_W-1:0]           wb_reg,
  output logic                       read_bank,
  output logic                       write_bank,
  output logic [WARP_W-1:0]          bank_warp_num,
  output logic                       rd_en0,
  output logic                       rd_en1,
  output logic [REG_W-1:0]           rd_addr0,
  output logic [REG_W-1:0]           rd_addr1,
  output logic [REG_W-1:0]           wr_addr,
  output logic                       rd_done_valid,
  output logic [WARP_W-1:0]          rd_done_warp
);

  localparam int STREAK_W = $clog2(WB_STREAK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RDC  = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WARP_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [STREAK_W-1:0] wb_streak_q, wb_streak_d;
  logic [REG_W-1:0]    pend_src1_q, pend_src1_d;
  logic                read_bank_q, read_bank_d;
  logic                write_bank_q, write_bank_d;
  logic [WARP_W-1:0]   bank_warp_num_q, bank_warp_num_d;
  logic                rd_en0_q, rd_en0_d;
  logic                rd_en1_q, rd_en1_d;
  logic [REG_W-1:0]    rd_addr0_q, rd_addr0_d;
  logic [REG_W-1:0]    rd_addr1_q, rd_addr1_d;
  logic [REG_W-1:0]    wr_addr_q, wr_addr_d;
  logic                rd_done_valid_q, rd_done_valid_d;
  logic [WARP_W-1:0]   rd_done_warp_q, rd_done_warp_d;

  logic [REG_W-1:0]    src0_arr [NUM_WARPS];
  logic [REG_W-1:0]    src1_arr [NUM_WARPS];
  logic [WARP_W-1:0]   winner;
  logic                any_req;
  logic                accept_win;
  logic                grant_wr;
  logic                grant_rd;
  logic [REG_W-1:0]    win_src0;
  logic [REG_W-1:0]    win_src1;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      src0_arr[w] = req_src0[w*REG_W +: REG_W];
      src1_arr[w] = req_src1[w*REG_W +: REG_W];
    end
  end

  // Round-robin search: first valid warp at or after rr_ptr, wrapping.
  always_comb begin
    logic [WARP_W-1:0] idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = WARP_W'((int'(rr_ptr_q) + i) % NUM_WARPS);
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  assign win_src0 = src0_arr[winner];
  assign win_src1 = src1_arr[winner];

  // The first half of a split read owns the next cycle, so no new accept then.
  assign accept_win = rst_n && (state_q != RDC);
  // Writeback wins unless it has already taken WB_STREAK_MAX grants in a row while reads wait.
  assign grant_wr   = accept_win && wb_valid &&
                      (!any_req || (wb_streak_q < STREAK_W'(WB_STREAK_MAX)));
  assign grant_rd   = accept_win && any_req && !grant_wr;

  always_comb begin
    req_ready = '0;
    if (grant_rd) req_ready[winner] = 1'b1;
  end
  assign wb_ready = grant_wr;

  always_comb begin
    state_d         = IDLE;
    rr_ptr_d        = rr_ptr_q;
    wb_streak_d     = wb_streak_q;
    pend_src1_d     = pend_src1_q;
    read_bank_d     = 1'b0;
    write_bank_d    = 1'b0;
    bank_warp_num_d = bank_warp_num_q;
    rd_en0_d        = 1'b0;
    rd_en1_d        = 1'b0;
    rd_addr0_d      = rd_addr0_q;
    rd_addr1_d      = rd_addr1_q;
    wr_addr_d       = wr_addr_q;
    rd_done_valid_d = 1'b0;
    rd_done_warp_d  = rd_done_warp_q;

    if (state_q == RDC) begin
      // Second half of a split read: operand 1 from the latched copy, same warp.
      state_d         = RD;
      read_bank_d     = 1'b1;
      rd_en1_d        = 1'b1;
      rd_addr1_d      = pend_src1_q;
      rd_done_valid_d = 1'b1;
      rd_done_warp_d  = bank_warp_num_q;
    end else if (grant_wr) begin
      state_d         = WR;
      write_bank_d    = 1'b1;
      wr_addr_d       = wb_reg;
      bank_warp_num_d = wb_warp;
      if (wb_streak_q < STREAK_W'(WB_STREAK_MAX)) wb_streak_d = wb_streak_q + STREAK_W'(1);
    end else if (grant_rd) begin
      read_bank_d     = 1'b1;
      rd_en0_d        = 1'b1;
      rd_addr0_d      = win_src0;
      bank_warp_num_d = winner;
      wb_streak_d     = '0;
      rr_ptr_d        = (winner == WARP_W'(NUM_WARPS - 1)) ? '0 : winner + WARP_W'(1);
      if (win_src0[1:0] != win_src1[1:0]) begin
        state_d         = RD;
        rd_en1_d        = 1'b1;
        rd_addr1_d      = win_src1;
        rd_done_valid_d = 1'b1;
        rd_done_warp_d  = winner;
      end else begin
        // Same bank: only one port can read it this cycle; hold operand 1 for the next.
        state_d     = RDC;
        pend_src1_d = win_src1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      wb_streak_q     <= '0;
      pend_src1_q     <= '0;
      read_bank_q     <= 1'b0;
      write_bank_q    <= 1'b0;
      bank_warp_num_q <= '0;
      rd_en0_q        <= 1'b0;
      rd_en1_q        <= 1'b0;
      rd_addr0_q      <= '0;
      rd_addr1_q      <= '0;
      wr_addr_q       <= '0;
      rd_done_valid_q <= 1'b0;
      rd_done_warp_q  <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      wb_streak_q     <= wb_streak_d;
      pend_src1_q     <= pend_src1_d;
      read_bank_q     <= read_bank_d;
      write_bank_q    <= write_bank_d;
      bank_warp_num_q <= bank_warp_num_d;
      rd_en0_q        <= rd_en0_d;
      rd_en1_q        <= rd_en1_d;
      rd_addr0_q      <= rd_addr0_d;
      rd_addr1_q      <= rd_addr1_d;
      wr_addr_q       <= wr_addr_d;
      rd_done_valid_q <= rd_done_valid_d;
      rd_done_warp_q  <= rd_done_warp_d;
    end
  end

  assign read_bank     = read_bank_q;
  assign write_bank    = write_bank_q;
  assign bank_warp_num = bank_warp_num_q;
  assign rd_en0        = rd_en0_q;
  assign rd_en1        = rd_en1_q;
  assign rd_addr0      = rd_addr0_q;
  assign rd_addr1      = rd_addr1_q;
  assign wr_addr       = wr_addr_q;
  assign rd_done_valid = rd_done_valid_q;
  assign rd_done_warp  = rd_done_warp_q;

endmodule

// File: tb/tb_gpu_bank_arbiter.sv
// Purpose : directed vector bench for gpu_bank_arbiter (reset, reads, splits, round-robin, wb cap).
// Latency : inputs driven at negedge, grants checked before posedge, registered outputs 1ns after.
// Backpr. : requesters drop valid after their grant cycle; writeback held to exercise the cap.
module tb_gpu_bank_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [19:0] req_src0;
  logic [19:0] req_src1;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  wb_warp;
  logic [4:0]  wb_reg;
  logic        read_bank;
  logic        write_bank;
  logic [1:0]  bank_warp_num;
  logic        rd_en0;
  logic        rd_en1;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic [4:0]  wr_addr;
  logic        rd_done_valid;
  logic [1:0]  rd_done_warp;

  gpu_bank_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src0(req_src0), .req_src1(req_src1),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp(wb_warp), .wb_reg(wb_reg),
    .read_bank(read_bank), .write_bank(write_bank), .bank_warp_num(bank_warp_num),
    .rd_en0(rd_en0), .rd_en1(rd_en1), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .wr_addr(wr_addr), .rd_done_valid(rd_done_valid), .rd_done_warp(rd_done_warp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rb;
    logic       wbk;
    logic [1:0] warp;
    logic       e0;
    logic       e1;
    logic [4:0] a0;
    logic [4:0] a1;
    logic [4:0] wa;
    logic       dv;
    logic [1:0] dw;
  } outs_t;

  typedef struct {
    logic        rst_n;
    logic [3:0]  rv;
    logic [19:0] s0;
    logic [19:0] s1;
    logic        wv;
    logic [1:0]  ww;
    logic [4:0]  wr;
    logic [3:0]  exp_rr;
    logic        exp_wbr;
    outs_t       exp_o;
  } vec_t;

  outs_t act_o;
  assign act_o = {read_bank, write_bank, bank_warp_num, rd_en0, rd_en1,
                  rd_addr0, rd_addr1, wr_addr, rd_done_valid, rd_done_warp};

  int checks;
  int errors;
  vec_t vecs [18];

  function automatic outs_t mko(input int rb, wbk, warp, e0, e1, a0, a1, wa, dv, dw);
    outs_t o;
    o = {1'(rb), 1'(wbk), 2'(warp), 1'(e0), 1'(e1), 5'(a0), 5'(a1), 5'(wa), 1'(dv), 2'(dw)};
    return o;
  endfunction

  function automatic logic [19:0] sp(input int a0, a1, a2, a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic vec_t mkv(input logic r, input logic [3:0] rv, input logic [19:0] s0, s1,
                               input logic wv, input logic [1:0] ww, input logic [4:0] wr,
                               input logic [3:0] exp_rr, input logic exp_wbr, input outs_t o);
    vec_t v;
    v.rst_n = r; v.rv = rv; v.s0 = s0; v.s1 = s1; v.wv = wv; v.ww = ww; v.wr = wr;
    v.exp_rr = exp_rr; v.exp_wbr = exp_wbr; v.exp_o = o;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [3:0] rv, input logic [19:0] s0, s1,
                       input logic wv, input logic [1:0] ww, input logic [4:0] wr);
    rst_n = r; req_valid = rv; req_src0 = s0; req_src1 = s1;
    wb_valid = wv; wb_warp = ww; wb_reg = wr;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    logic [19:0] s0_all, s1_all;
    checks = 0;
    errors = 0;
    drive(1'b0, 4'b0, '0, '0, 1'b0, 2'd0, 5'd0);
    s0_all = sp(0, 5, 1, 9);
    s1_all = sp(1, 6, 2, 10);

    // reset with every request asserted: grants forced low, outputs zero
    vecs[0]  = mkv(0, 4'b1111, s0_all, s1_all, 1, 2, 7, 4'b0000, 0, mko(0,0,0,0,0,0,0,0,0,0));
    vecs[1]  = mkv(0, 4'b0000, '0, '0, 0, 0, 0, 4'b0000, 0, mko(0,0,0,0,0,0,0,0,0,0));
    // warp1 5/6, different banks: single-cycle read
    vecs[2]  = mkv(1, 4'b0010, sp(0,5,0,0), sp(0,6,0,0), 0, 0, 0, 4'b0010, 0, mko(1,0,1,1,1,5,6,0,1,1));
    vecs[3]  = mkv(1, 4'b0000, '0, '0, 0, 0, 0, 4'b0000, 0, mko(0,0,1,0,0,5,6,0,0,1));
    // warp0 4/8 share bank 0: split; nothing accepted during first half
    vecs[4]  = mkv(1, 4'b0001, sp(4,0,0,0), sp(8,0,0,0), 0, 0, 0, 4'b0001, 0, mko(1,0,0,1,0,4,6,0,0,1));
    vecs[5]  = mkv(1, 4'b0010, sp(0,5,0,0), sp(0,6,0,0), 1, 2, 7, 4'b0000, 0, mko(1,0,0,0,1,4,8,0,1,0));
    // writeback beats the read, then warp2 read with no bubble
    vecs[6]  = mkv(1, 4'b0010, sp(0,5,0,0), sp(0,6,0,0), 1, 2, 7, 4'b0000, 1, mko(0,1,2,0,0,4,8,7,0,0));
    vecs[7]  = mkv(1, 4'b0100, sp(0,0,1,0), sp(0,0,2,0), 0, 0, 0, 4'b0100, 0, mko(1,0,2,1,1,1,2,7,1,2));
    // all four warps requesting: rr pointer starts at 3 -> 3,0,1,2,3,0
    vecs[8]  = mkv(1, 4'b1111, s0_all, s1_all, 0, 0, 0, 4'b1000, 0, mko(1,0,3,1,1,9,10,7,1,3));
    vecs[9]  = mkv(1, 4'b1111, s0_all, s1_all, 0, 0, 0, 4'b0001, 0, mko(1,0,0,1,1,0,1,7,1,0));
    vecs[10] = mkv(1, 4'b1111, s0_all, s1_all, 0, 0, 0, 4'b0010, 0, mko(1,0,1,1,1,5,6,7,1,1));
    vecs[11] = mkv(1, 4'b1111, s0_all, s1_all, 0, 0, 0, 4'b0100, 0, mko(1,0,2,1,1,1,2,7,1,2));
    vecs[12] = mkv(1, 4'b1111, s0_all, s1_all, 0, 0, 0, 4'b1000, 0, mko(1,0,3,1,1,9,10,7,1,3));
    vecs[13] = mkv(1, 4'b1111, s0_all, s1_all, 0, 0, 0, 4'b0001, 0, mko(1,0,0,1,1,0,1,7,1,0));
    vecs[14] = mkv(1, 4'b0000, '0, '0, 0, 0, 0, 4'b0000, 0, mko(0,0,0,0,0,0,1,7,0,0));
    // src0 == src1 also splits
    vecs[15] = mkv(1, 4'b0010, sp(0,3,0,0), sp(0,3,0,0), 0, 0, 0, 4'b0010, 0, mko(1,0,1,1,0,3,1,7,0,0));
    vecs[16] = mkv(1, 4'b0000, '0, '0, 0, 0, 0, 4'b0000, 0, mko(1,0,1,0,1,3,3,7,1,1));
    vecs[17] = mkv(1, 4'b0000, '0, '0, 0, 0, 0, 4'b0000, 0, mko(0,0,1,0,0,3,3,7,0,1));

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].rv, vecs[i].s0, vecs[i].s1, vecs[i].wv, vecs[i].ww, vecs[i].wr);
      #1;
      chk($sformatf("vec%0d ready", i), {27'b0, req_ready, wb_ready}, {27'b0, vecs[i].exp_rr, vecs[i].exp_wbr});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d outs", i), {8'b0, act_o}, {8'b0, vecs[i].exp_o});
    end

    // Writeback cap: wb, wb, wb, read(w3), repeated, while both keep asking.
    for (int i = 0; i < 8; i++) begin
      logic exp_wb;
      exp_wb = (i % 4) != 3;
      @(negedge clk);
      drive(1'b1, 4'b1000, sp(0,0,0,12), sp(0,0,0,13), 1'b1, 2'd1, 5'd11);
      #1;
      chk($sformatf("cap%0d wb_ready", i), {31'b0, wb_ready}, {31'b0, exp_wb});
      chk($sformatf("cap%0d req_ready", i), {28'b0, req_ready}, {28'b0, exp_wb ? 4'b0000 : 4'b1000});
      @(posedge clk);
      #1;
      chk($sformatf("cap%0d strobes", i), {30'b0, write_bank, read_bank}, {30'b0, exp_wb, !exp_wb});
    end

    // Streak saturates during an uncontested writeback run; a read then wins at once.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 4'b0000, '0, '0, 1'b1, 2'd1, 5'd11);
      #1;
      chk($sformatf("wbrun%0d wb_ready", i), {31'b0, wb_ready}, 32'd1);
    end
    @(negedge clk);
    drive(1'b1, 4'b1000, sp(0,0,0,12), sp(0,0,0,13), 1'b1, 2'd1, 5'd11);
    #1;
    chk("sat read_wins", {27'b0, req_ready, wb_ready}, {27'b0, 4'b1000, 1'b0});

    // Reset during the first half of a split read of warp 2.
    @(negedge clk);
    drive(1'b1, 4'b0100, sp(0,0,4,0), sp(0,0,8,0), 1'b0, 2'd0, 5'd0);
    #1;
    chk("rst_mid ready", {28'b0, req_ready}, 32'h4);
    @(posedge clk);
    #1;
    chk("rst_mid rdc", {28'b0, rd_en0, rd_en1, bank_warp_num}, {28'b0, 1'b1, 1'b0, 2'd2});
    @(negedge clk);
    drive(1'b0, 4'b0000, '0, '0, 1'b0, 2'd0, 5'd0);
    @(posedge clk);
    #1;
    chk("rst_mid outs", {8'b0, act_o}, 32'h0);
    chk("rst_mid no_done", {31'b0, rd_done_valid}, 32'h0);
    @(negedge clk);
    drive(1'b1, 4'b1111, s0_all, s1_all, 1'b0, 2'd0, 5'd0);
    #1;
    chk("rst_mid rr_ptr0", {28'b0, req_ready}, 32'h1);
    @(negedge clk);
    drive(1'b1, 4'b0000, '0, '0, 1'b0, 2'd0, 5'd0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
